// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller at the ID/EX boundary: tracks in-flight destinations
// per stage and resolves each ID source to register file, a forwarding slot, or a stall.
module hazard_scoreboard #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int STAGES = 3,
    parameter int LW     = $clog2(STAGES),
    localparam int AW    = $clog2(NREG)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   id_valid_i,
    input  logic [AW-1:0]          id_rs1_i,
    input  logic [AW-1:0]          id_rs2_i,
    input  logic                   id_rs1_use_i,
    input  logic                   id_rs2_use_i,
    input  logic [AW-1:0]          id_rd_i,
    input  logic                   id_wr_en_i,
    input  logic [LW-1:0]          id_rdy_i,
    input  logic [XLEN-1:0]        rf_rs1_data_i,
    input  logic [XLEN-1:0]        rf_rs2_data_i,
    input  logic [STAGES*XLEN-1:0] stg_data_i,
    input  logic                   ext_stall_i,
    input  logic                   flush_i,
    output logic                   stall_o,
    output logic                   issue_o,
    output logic [XLEN-1:0]        rs1_data_o,
    output logic [XLEN-1:0]        rs2_data_o,
    output logic [LW:0]            rs1_fwd_o,
    output logic [LW:0]            rs2_fwd_o,
    output logic [AW:0]            inflight_o
);

    typedef struct packed {
        logic            haz;
        logic [LW:0]     fwd;
        logic [XLEN-1:0] data;
    } lookup_t;

    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] we_q, we_d;
    logic [AW-1:0]     rd_q  [STAGES];
    logic [AW-1:0]     rd_d  [STAGES];
    logic [LW-1:0]     rdy_q [STAGES];
    logic [LW-1:0]     rdy_d [STAGES];
    logic [AW:0]       inflight_q, inflight_d;

    logic [STAGES-1:0] hit1, hit2, ready;
    logic              new_we;
    logic [LW-1:0]     new_rdy;
    lookup_t           lk1, lk2;

    // Per-slot match and readiness: slot k holds a usable result once k has reached rdy.
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_slot
        assign hit1[gi]  = v_q[gi] && we_q[gi] && (rd_q[gi] == id_rs1_i);
        assign hit2[gi]  = v_q[gi] && we_q[gi] && (rd_q[gi] == id_rs2_i);
        assign ready[gi] = (LW'(gi) >= rdy_q[gi]);
    end

    // Scan oldest to youngest so the youngest match overrides every older one.
    function automatic lookup_t lookup(
        input logic [STAGES-1:0]      hit,
        input logic [STAGES-1:0]      rdy_vec,
        input logic                   use_src,
        input logic [AW-1:0]          rs,
        input logic [XLEN-1:0]        rf,
        input logic [STAGES*XLEN-1:0] stg,
        input logic                   rst
    );
        lookup_t r;
        r.haz  = 1'b0;
        r.fwd  = '0;
        r.data = rf;
        if (use_src && (rs != '0) && !rst) begin
            for (int k = STAGES - 1; k >= 0; k--) begin
                if (hit[k]) begin
                    if (rdy_vec[k]) begin
                        r.haz  = 1'b0;
                        r.fwd  = (LW+1)'(k + 1);
                        r.data = stg[k*XLEN +: XLEN];
                    end else begin
                        r.haz  = 1'b1;
                        r.fwd  = '0;
                        r.data = rf;
                    end
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        lk1 = lookup(hit1, ready, id_rs1_use_i, id_rs1_i, rf_rs1_data_i, stg_data_i, rst_i);
        lk2 = lookup(hit2, ready, id_rs2_use_i, id_rs2_i, rf_rs2_data_i, stg_data_i, rst_i);
    end

    assign stall_o    = id_valid_i && (lk1.haz || lk2.haz) && !rst_i;
    assign issue_o    = id_valid_i && !stall_o && !ext_stall_i && !flush_i && !rst_i;
    assign rs1_data_o = lk1.data;
    assign rs2_data_o = lk2.data;
    assign rs1_fwd_o  = lk1.fwd;
    assign rs2_fwd_o  = lk2.fwd;
    assign inflight_o = inflight_q;

    assign new_we  = id_wr_en_i && (id_rd_i != '0);
    assign new_rdy = (id_rdy_i > LW'(STAGES - 1)) ? LW'(STAGES - 1) : id_rdy_i;

    always_comb begin
        v_d        = v_q;
        we_d       = we_q;
        rd_d       = rd_q;
        rdy_d      = rdy_q;
        inflight_d = inflight_q;
        if (!ext_stall_i) begin
            for (int k = STAGES - 1; k >= 1; k--) begin
                v_d[k]   = v_q[k-1];
                we_d[k]  = we_q[k-1];
                rd_d[k]  = rd_q[k-1];
                rdy_d[k] = rdy_q[k-1];
            end
            v_d[0]   = issue_o;
            we_d[0]  = issue_o && new_we;
            rd_d[0]  = id_rd_i;
            rdy_d[0] = new_rdy;
            // Shift-in and retirement of writers may cancel in the same edge.
            case ({issue_o && new_we, v_q[STAGES-1] && we_q[STAGES-1]})
                2'b10:   inflight_d = inflight_q + (AW+1)'(1);
                2'b01:   inflight_d = inflight_q - (AW+1)'(1);
                default: inflight_d = inflight_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v_q        <= '0;
            we_q       <= '0;
            inflight_q <= '0;
        end else begin
            v_q        <= v_d;
            we_q       <= we_d;
            inflight_q <= inflight_d;
        end
        rd_q  <= rd_d;
        rdy_q <= rdy_d;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (STAGES = 3) plus a randomized occupancy run
// on a STAGES = 4 instance checked against a popcount reference.
module tb_hazard_scoreboard;

    int errors = 0;
    int checks = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, use1, use2, wen, ext, flush;
    logic [4:0]  rs1, rs2, rd;
    logic [1:0]  rdy;
    logic [31:0] rf1, rf2;
    logic [95:0] stg;
    logic        stall, issue;
    logic [31:0] d1, d2;
    logic [2:0]  f1, f2;
    logic [5:0]  infl;

    logic         valid4, wen4, ext4, flush4;
    logic [4:0]   rd4;
    logic [1:0]   rdy4;
    logic [127:0] stg4;
    logic         stall4, issue4;
    logic [31:0]  d1_4, d2_4;
    logic [2:0]   f1_4, f2_4;
    logic [5:0]   infl4;

    always #5 clk = ~clk;

    hazard_scoreboard #(.XLEN(32), .NREG(32), .STAGES(3)) u3 (
        .clk_i(clk), .rst_i(rst), .id_valid_i(valid),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rs1_use_i(use1), .id_rs2_use_i(use2),
        .id_rd_i(rd), .id_wr_en_i(wen), .id_rdy_i(rdy),
        .rf_rs1_data_i(rf1), .rf_rs2_data_i(rf2), .stg_data_i(stg),
        .ext_stall_i(ext), .flush_i(flush),
        .stall_o(stall), .issue_o(issue), .rs1_data_o(d1), .rs2_data_o(d2),
        .rs1_fwd_o(f1), .rs2_fwd_o(f2), .inflight_o(infl)
    );

    hazard_scoreboard #(.XLEN(32), .NREG(32), .STAGES(4)) u4 (
        .clk_i(clk), .rst_i(rst), .id_valid_i(valid4),
        .id_rs1_i(5'd1), .id_rs2_i(5'd2), .id_rs1_use_i(1'b0), .id_rs2_use_i(1'b0),
        .id_rd_i(rd4), .id_wr_en_i(wen4), .id_rdy_i(rdy4),
        .rf_rs1_data_i(32'h0000_0A11), .rf_rs2_data_i(32'h0000_0B22), .stg_data_i(stg4),
        .ext_stall_i(ext4), .flush_i(flush4),
        .stall_o(stall4), .issue_o(issue4), .rs1_data_o(d1_4), .rs2_data_o(d2_4),
        .rs1_fwd_o(f1_4), .rs2_fwd_o(f2_4), .inflight_o(infl4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setid(input logic v, input logic [4:0] a, input logic ua,
                         input logic [4:0] b, input logic ub,
                         input logic [4:0] d, input logic w, input logic [1:0] y);
        valid = v; rs1 = a; use1 = ua; rs2 = b; use2 = ub; rd = d; wen = w; rdy = y;
    endtask

    initial begin
        logic [3:0] mv;
        logic       exp_issue;
        int         pc;

        rst = 1'b1; ext = 1'b0; flush = 1'b0;
        rf1 = 32'h1111_0001; rf2 = 32'h2222_0002;
        stg = {32'hDEAD_BEEF, 32'h0000_00B1, 32'h0000_00A0};
        setid(1'b1, 5'd6, 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 2'd1);
        valid4 = 1'b0; wen4 = 1'b0; ext4 = 1'b0; flush4 = 1'b0; rd4 = 5'd0; rdy4 = 2'd0;
        stg4 = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};

        // reset held two edges with a valid ID instruction
        #2;
        chk("rst_stall_c1", stall, 1'b0);
        chk("rst_issue_c1", issue, 1'b0);
        tick();
        #2;
        chk("rst_stall_c2", stall, 1'b0);
        chk("rst_issue_c2", issue, 1'b0);
        chk("rst_inflight", infl, 6'd0);
        chk("rst_fwd1", f1, 3'd0);
        chk("rst_data1", d1, 32'h1111_0001);
        tick();

        rst = 1'b0;
        setid(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 2'd1);   // addi x5
        #2;
        chk("addi_issue", issue, 1'b1);
        tick();

        setid(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 2'd2);   // lw x6
        #2;
        chk("addi_inflight", infl, 6'd1);
        chk("lw_issue", issue, 1'b1);
        tick();

        setid(1'b1, 5'd6, 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 2'd1);   // add x7,x6,x1
        #2;
        chk("lu_inflight", infl, 6'd2);
        chk("lu_stall1", stall, 1'b1);
        chk("lu_issue1", issue, 1'b0);
        chk("lu_fwd2", f2, 3'd0);
        chk("lu_data2", d2, 32'h2222_0002);
        tick();
        #2;
        chk("lu_stall2", stall, 1'b1);
        tick();
        #2;
        chk("lu_stall3", stall, 1'b0);
        chk("lu_fwd1", f1, 3'd3);
        chk("lu_data1", d1, 32'hDEAD_BEEF);
        chk("lu_issue3", issue, 1'b1);
        chk("lu_inflight3", infl, 6'd1);
        tick();

        // two writers of x3 end up in slots 2 and 1
        setid(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 2'd1);
        #2;
        chk("yw_inflight_a", infl, 6'd1);
        tick();
        #2;
        chk("yw_inflight_b", infl, 6'd2);
        tick();
        valid = 1'b0;
        #2;
        chk("yw_inflight_c", infl, 6'd3);
        tick();
        stg = {32'd11, 32'd22, 32'h0000_00A0};
        setid(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd1);
        #2;
        chk("yw_data1", d1, 32'd22);
        chk("yw_fwd1", f1, 3'd2);
        chk("yw_stall", stall, 1'b0);
        chk("yw_inflight_d", infl, 6'd2);
        tick();

        // writes to x0 never count, and x0 / unused sources never hazard
        setid(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 2'd1);
        #2;
        chk("x0_inflight_a", infl, 6'd1);
        chk("x0_issue", issue, 1'b1);
        tick();
        setid(1'b1, 5'd0, 1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 2'd1);
        #2;
        chk("x0_stall", stall, 1'b0);
        chk("x0_fwd1", f1, 3'd0);
        chk("x0_fwd2", f2, 3'd0);
        chk("x0_data1", d1, 32'h1111_0001);
        chk("x0_data2", d2, 32'h2222_0002);
        chk("x0_inflight_b", infl, 6'd0);
        tick();

        stg = {32'hDEAD_BEEF, 32'h0000_00B1, 32'h0000_00A0};
        setid(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 2'd2);   // lw x6
        #2;
        chk("x0_inflight_c", infl, 6'd0);
        chk("es_lw_issue", issue, 1'b1);
        tick();

        // freeze the pipeline while the load sits in slot 0
        setid(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 2'd1);
        ext = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("es_stall", stall, 1'b1);
            chk("es_issue", issue, 1'b0);
            chk("es_inflight", infl, 6'd1);
            tick();
        end
        ext = 1'b0;
        #2;
        chk("es_resume_stall1", stall, 1'b1);
        chk("es_resume_issue1", issue, 1'b0);
        tick();
        #2;
        chk("es_resume_stall2", stall, 1'b1);
        tick();
        #2;
        chk("es_resume_fwd1", f1, 3'd3);
        chk("es_resume_data1", d1, 32'hDEAD_BEEF);
        chk("es_resume_issue3", issue, 1'b1);
        chk("es_resume_inflight", infl, 6'd1);
        tick();

        // flush of a hazard-free instruction inserts a bubble
        setid(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 2'd1);
        flush = 1'b1;
        #2;
        chk("fl_issue", issue, 1'b0);
        chk("fl_stall", stall, 1'b0);
        tick();
        flush = 1'b0;
        setid(1'b1, 5'd8, 1'b1, 5'd7, 1'b1, 5'd10, 1'b1, 2'd2);
        #2;
        chk("fl_fwd1", f1, 3'd0);
        chk("fl_data1", d1, 32'h1111_0001);
        chk("fl_fwd2", f2, 3'd2);
        chk("fl_data2", d2, 32'h0000_00B1);
        chk("fl_inflight", infl, 6'd1);
        tick();

        // flush coinciding with a hazard
        setid(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 2'd1);
        flush = 1'b1;
        #2;
        chk("flh_stall", stall, 1'b1);
        chk("flh_issue", issue, 1'b0);
        chk("flh_inflight", infl, 6'd2);
        tick();

        // reset mid-operation: outputs neutral, slots emptied at the edge
        flush = 1'b0;
        rst = 1'b1;
        #2;
        chk("mr_stall", stall, 1'b0);
        chk("mr_issue", issue, 1'b0);
        chk("mr_fwd1", f1, 3'd0);
        chk("mr_data1", d1, 32'h1111_0001);
        chk("mr_inflight", infl, 6'd1);
        tick();
        rst = 1'b0;
        #2;
        chk("mr_after_inflight", infl, 6'd0);
        chk("mr_after_stall", stall, 1'b0);
        chk("mr_after_fwd1", f1, 3'd0);
        tick();
        valid = 1'b0;

        // randomized occupancy run on the four-stage instance
        mv = 4'b0000;
        for (int i = 0; i < 200; i++) begin
            valid4 = ($urandom_range(0, 3) != 0);
            wen4   = ($urandom_range(0, 3) != 0);
            rd4    = 5'($urandom_range(0, 31));
            rdy4   = 2'($urandom_range(0, 3));
            ext4   = ($urandom_range(0, 7) == 0);
            flush4 = ($urandom_range(0, 7) == 0);
            exp_issue = valid4 && !ext4 && !flush4;
            pc = 0;
            for (int k = 0; k < 4; k++) pc += int'(mv[k]);
            #2;
            chk("rnd_issue", issue4, exp_issue);
            chk("rnd_inflight", infl4, 6'(pc));
            chk("rnd_stall", stall4, 1'b0);
            chk("rnd_fwd", {f1_4, f2_4}, 6'd0);
            chk("rnd_data", {d1_4, d2_4}, {32'h0000_0A11, 32'h0000_0B22});
            tick();
            if (!ext4) mv = {mv[2:0], exp_issue && wen4 && (rd4 != 5'd0)};
        end
        valid4 = 1'b0;
        pc = 0;
        for (int k = 0; k < 4; k++) pc += int'(mv[k]);
        #2;
        chk("rnd_final_inflight", infl4, 6'(pc));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
